// File: rtl/serial_slave_port.sv
// serial_slave_port: responder end of the serial system bus.
// Deserialises address, burst count and write data (all LSB first), serves a
// local word memory, and serialises read data back to the master.
//
// Handshake: an input bit (rx_address / rx_burst_num / rx_data) is consumed
// on a rising edge only when master_valid=1 and slave_ready=1; an output bit
// on tx_data advances only when slave_valid=1 and master_ready=1. Any other
// combination stalls the current phase for as long as it lasts.
module serial_slave_port #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int BURST_W  = 8,
  parameter int READ_LAT = 2,
  parameter int SPLIT_EN = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       master_valid,
  input  logic       master_ready,
  input  logic       rx_address,
  input  logic       rx_burst_num,
  input  logic       rx_data,
  input  logic       write_en,
  input  logic       read_en,
  output logic       tx_data,
  output logic       slave_valid,
  output logic       slave_ready,
  output logic       slave_split_en,
  output logic       trans_done,
  output logic [2:0] state_dbg
);

  localparam int MAX_AB = (ADDR_W > BURST_W) ? ADDR_W : BURST_W;
  localparam int MAX_W  = (MAX_AB > DATA_W) ? MAX_AB : DATA_W;
  localparam int CNT_W  = $clog2(MAX_W) + 1;

  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  // READ_LAT of 0 still needs one wait cycle to load the memory word
  localparam logic [3:0] LAT_LAST = 4'((READ_LAT == 0) ? 0 : READ_LAT - 1);
  localparam logic SPLIT_VAL = (SPLIT_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_WDATA = 3'd3,
    S_RWAIT = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state;
  logic               is_read;
  logic [ADDR_W-1:0]  addr;
  logic [BURST_W-1:0] beats;
  logic [DATA_W-1:0]  data_sh;
  logic [CNT_W-1:0]   bit_cnt;
  logic [3:0]         lat_cnt;

  logic [DATA_W-1:0]  mem [0:(1 << ADDR_W) - 1];

  logic               in_take;
  logic               out_take;
  logic [ADDR_W-1:0]  addr_next;
  logic [BURST_W-1:0] burst_next;
  logic [DATA_W-1:0]  wdata_next;
  logic [DATA_W-1:0]  rd_word;
  logic               mem_we;

  assign state_dbg  = state;
  assign in_take    = master_valid & slave_ready;
  assign out_take   = slave_valid & master_ready;
  // Fields arrive LSB first, so each new bit enters at the top and shifts down
  assign addr_next  = {rx_address, addr[ADDR_W-1:1]};
  assign burst_next = {rx_burst_num, beats[BURST_W-1:1]};
  assign wdata_next = {rx_data, data_sh[DATA_W-1:1]};
  assign rd_word    = mem[addr];
  assign mem_we     = (state == S_WDATA) && in_take && (bit_cnt == DATA_LAST);

  // Local word memory: one write at the edge that completes a write beat
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem[addr] <= wdata_next;
  end

  // Transaction FSM with registered handshake outputs
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state          <= S_IDLE;
      is_read        <= 1'b0;
      addr           <= '0;
      beats          <= '0;
      data_sh        <= '0;
      bit_cnt        <= '0;
      lat_cnt        <= '0;
      tx_data        <= 1'b0;
      slave_valid    <= 1'b0;
      slave_ready    <= 1'b1;
      slave_split_en <= 1'b0;
      trans_done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Both enables at once is not a legal op and is simply ignored
          if (master_valid && (write_en ^ read_en)) begin
            is_read <= read_en;
            addr    <= addr_next;
            bit_cnt <= CNT_W'(1);
            state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (in_take) begin
            addr <= addr_next;
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= S_BURST;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_BURST: begin
          if (in_take) begin
            if (bit_cnt == BURST_LAST) begin
              bit_cnt <= '0;
              // A zero burst field still moves one beat
              beats   <= (burst_next == '0) ? BURST_W'(1) : burst_next;
              if (is_read) begin
                state          <= S_RWAIT;
                slave_ready    <= 1'b0;
                slave_split_en <= SPLIT_VAL;
                lat_cnt        <= '0;
              end else begin
                state <= S_WDATA;
              end
            end else begin
              beats   <= burst_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_WDATA: begin
          if (in_take) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              addr    <= addr + ADDR_W'(1);
              beats   <= beats - BURST_W'(1);
              if (beats == BURST_W'(1)) begin
                state       <= S_DONE;
                slave_ready <= 1'b0;
                trans_done  <= 1'b1;
              end
            end else begin
              data_sh <= wdata_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_RWAIT: begin
          if (lat_cnt == LAT_LAST) begin
            data_sh        <= rd_word;
            tx_data        <= rd_word[0];
            slave_valid    <= 1'b1;
            slave_split_en <= 1'b0;
            state          <= S_RDATA;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        S_RDATA: begin
          if (out_take) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt     <= '0;
              addr        <= addr + ADDR_W'(1);
              beats       <= beats - BURST_W'(1);
              slave_valid <= 1'b0;
              tx_data     <= 1'b0;
              if (beats == BURST_W'(1)) begin
                state      <= S_DONE;
                trans_done <= 1'b1;
              end else begin
                state          <= S_RWAIT;
                slave_split_en <= SPLIT_VAL;
                lat_cnt        <= '0;
              end
            end else begin
              data_sh <= {1'b0, data_sh[DATA_W-1:1]};
              tx_data <= data_sh[1];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          trans_done  <= 1'b0;
          slave_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Testbench for serial_slave_port. Two instances share one clock and reset:
// u_dut0 uses the default parameters, u_dut1 uses READ_LAT=0, SPLIT_EN=0.
// sel steers the shared driver signals to one instance and muxes its outputs.
module tb_serial_slave_port;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared drive signals ----------------
  logic sel;
  logic mv, mr, rxa, rxb, rxd, wen, ren;

  logic mv0, mr0, wen0, ren0, mv1, mr1, wen1, ren1;
  assign mv0  = mv  & ~sel;
  assign mr0  = mr  & ~sel;
  assign wen0 = wen & ~sel;
  assign ren0 = ren & ~sel;
  assign mv1  = mv  & sel;
  assign mr1  = mr  & sel;
  assign wen1 = wen & sel;
  assign ren1 = ren & sel;

  logic tx0, sv0, sr0, sp0, td0;
  logic tx1, sv1, sr1, sp1, td1;
  logic [2:0] st0, st1;

  logic tx, sv, sr, sp, td;
  logic [2:0] st;
  assign tx = sel ? tx1 : tx0;
  assign sv = sel ? sv1 : sv0;
  assign sr = sel ? sr1 : sr0;
  assign sp = sel ? sp1 : sp0;
  assign td = sel ? td1 : td0;
  assign st = sel ? st1 : st0;

  serial_slave_port u_dut0 (
    .sys_clk(clk), .sys_rst(sys_rst),
    .master_valid(mv0), .master_ready(mr0),
    .rx_address(rxa), .rx_burst_num(rxb), .rx_data(rxd),
    .write_en(wen0), .read_en(ren0),
    .tx_data(tx0), .slave_valid(sv0), .slave_ready(sr0),
    .slave_split_en(sp0), .trans_done(td0), .state_dbg(st0)
  );

  serial_slave_port #(.READ_LAT(0), .SPLIT_EN(0)) u_dut1 (
    .sys_clk(clk), .sys_rst(sys_rst),
    .master_valid(mv1), .master_ready(mr1),
    .rx_address(rxa), .rx_burst_num(rxb), .rx_data(rxd),
    .write_en(wen1), .read_en(ren1),
    .tx_data(tx1), .slave_valid(sv1), .slave_ready(sr1),
    .slave_split_en(sp1), .trans_done(td1), .state_dbg(st1)
  );

  // ---------------- scoreboard state ----------------
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         td_cnt    = 0;
  int         consumed  = 0;
  int         split_cnt = 0;
  int         ready_low = 0;
  logic [7:0] wbuf [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] rbyte;
  int         rbit = 0;
  logic       hold = 1'b0;
  logic       hold_bit;
  logic [7:0] e;

  // Samples on the falling edge: counts events, assembles read bytes and
  // compares each completed byte with the head of the expected queue
  always @(negedge clk) begin
    if (sys_rst) begin
      if (td) td_cnt++;
      if (mv && sr) consumed++;
      if (sp) split_cnt++;
      if (sv && mr) begin
        rbyte[rbit[2:0]] = tx;
        rbit++;
        hold = 1'b0;
        if (rbit == 8) begin
          rbit = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no byte", rbyte);
          end else begin
            e = exp_q.pop_front();
            check("rd_byte", {24'd0, rbyte}, {24'd0, e});
          end
        end
      end else if (sv && !mr) begin
        if (hold) check("tx_hold", {31'd0, tx}, {31'd0, hold_bit});
        hold     = 1'b1;
        hold_bit = tx;
      end else begin
        hold = 1'b0;
      end
    end else begin
      rbit = 0;
      hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // ch: 0 = address line, 1 = burst line, 2 = data line
  task automatic send_bit(input int ch, input logic b, input bit stall);
    bit done_ok;
    if (stall && $urandom_range(0, 2) == 0) begin
      mv = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    mv = 1'b1;
    case (ch)
      0:       rxa = b;
      1:       rxb = b;
      default: rxd = b;
    endcase
    done_ok = 1'b0;
    for (int t = 0; t < 50 && !done_ok; t++) begin
      @(negedge clk);
      if (sr) begin
        @(posedge clk);
        #1;
        done_ok = 1'b1;
      end else begin
        ready_low++;
      end
    end
    if (!done_ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_header(input bit rd, input logic [11:0] a, input logic [7:0] bn, input bit stall);
    wen = !rd;
    ren = rd;
    send_bit(0, a[0], 1'b0);
    wen = 1'b0;
    ren = 1'b0;
    for (int i = 1; i < 12; i++) send_bit(0, a[i], stall);
    for (int i = 0; i < 8; i++) send_bit(1, bn[i], stall);
    mv = 1'b0;
  endtask

  // Wait (bounded) for trans_done, then confirm it lasted a single cycle
  task automatic wait_done(input string name);
    for (int t = 0; t < 300 && !td; t++) begin
      @(posedge clk);
      #1;
    end
    check(name, {31'd0, td}, 32'd1);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, td}, 32'd0);
    check("idle_ready", {31'd0, sr}, 32'd1);
  endtask

  // abort_at >= 0 stops driving after that many data bits (no done wait)
  task automatic do_write(input logic [11:0] a, input logic [7:0] bn, input int nbeats,
                          input bit stall, input int abort_at);
    send_header(1'b0, a, bn, stall);
    for (int k = 0; k < nbeats * 8; k++) begin
      if (k == abort_at) begin
        mv = 1'b0;
        return;
      end
      send_bit(2, wbuf[k / 8][k % 8], stall);
    end
    mv = 1'b0;
    wait_done("wr_done");
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] bn, input bit stall,
                         input int exp_lat, input int exp_split);
    int sc0;
    int c0;
    int lat;
    mr  = 1'b1;
    sc0 = split_cnt;
    send_header(1'b1, a, bn, 1'b0);
    c0  = cyc;
    lat = -1;
    for (int t = 0; t < 40 && lat < 0; t++) begin
      if (sv) lat = cyc - c0;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("rd_lat", lat, exp_lat);
    for (int t = 0; t < 600 && !td; t++) begin
      mr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
    end
    mr = 1'b1;
    check("rd_done", {31'd0, td}, 32'd1);
    check("rd_split", split_cnt - sc0, exp_split);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, td}, 32'd0);
    check("rd_q_empty", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    check("watchdog", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  int c_before;
  int td_before;

  initial begin
    sel = 1'b0; mv = 1'b0; mr = 1'b1; rxa = 1'b0; rxb = 1'b0; rxd = 1'b0;
    wen = 1'b0; ren = 1'b0;
    sys_rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, sr}, 32'd1);
    check("rst_valid", {31'd0, sv}, 32'd0);
    check("rst_split", {31'd0, sp}, 32'd0);
    check("rst_done",  {31'd0, td}, 32'd0);
    check("rst_tx",    {31'd0, tx}, 32'd0);
    check("rst_state", {29'd0, st}, 32'd0);
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read: 0x3C at 0x0A5
    c_before  = consumed;
    ready_low = 0;
    wbuf[0]   = 8'h3C;
    do_write(12'h0A5, 8'd1, 1, 1'b0, -1);
    check("wr_bits_consumed", consumed - c_before, 28);
    check("wr_ready_low", ready_low, 0);
    exp_q.push_back(8'h3C);
    do_read(12'h0A5, 8'd1, 1'b0, 2, 2);

    // Burst write across the top of the address space
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(12'hFFE, 8'd3, 3, 1'b0, -1);
    exp_q.push_back(8'h33);
    do_read(12'h000, 8'd1, 1'b0, 2, 2);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    do_read(12'hFFE, 8'd2, 1'b0, 2, 4);

    // Stalls on both directions
    wbuf[0] = 8'hA7; wbuf[1] = 8'h5E;
    do_write(12'h300, 8'd2, 2, 1'b1, -1);
    exp_q.push_back(8'hA7);
    exp_q.push_back(8'h5E);
    do_read(12'h300, 8'd2, 1'b1, 2, 4);

    // Burst field of zero moves one beat
    wbuf[0] = 8'h5D;
    do_write(12'h200, 8'd0, 1, 1'b0, -1);
    exp_q.push_back(8'h5D);
    do_read(12'h200, 8'd0, 1'b0, 2, 2);

    // Both enables: must stay idle with no done pulse
    td_before = td_cnt;
    wen = 1'b1; ren = 1'b1; mv = 1'b1; rxa = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("both_en_state", {29'd0, st}, 32'd0);
    end
    wen = 1'b0; ren = 1'b0; mv = 1'b0;
    @(posedge clk);
    #1;
    check("both_en_no_done", td_cnt - td_before, 0);

    // Reset during the second beat of a three-beat write
    wbuf[0] = 8'h5A;
    do_write(12'h101, 8'd1, 1, 1'b0, -1);
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
    do_write(12'h100, 8'd3, 3, 1'b0, 11);
    sys_rst = 1'b0;
    #1;
    check("midrst_ready", {31'd0, sr}, 32'd1);
    check("midrst_valid", {31'd0, sv}, 32'd0);
    check("midrst_done",  {31'd0, td}, 32'd0);
    check("midrst_state", {29'd0, st}, 32'd0);
    @(negedge clk);
    sys_rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h5A);
    do_read(12'h100, 8'd2, 1'b0, 2, 4);
    wbuf[0] = 8'h77;
    do_write(12'h101, 8'd1, 1, 1'b0, -1);
    exp_q.push_back(8'h77);
    do_read(12'h101, 8'd1, 1'b0, 2, 2);

    // READ_LAT=0, SPLIT_EN=0 instance
    sel = 1'b1;
    @(posedge clk);
    #1;
    wbuf[0] = 8'hC9;
    do_write(12'h0A5, 8'd1, 1, 1'b0, -1);
    exp_q.push_back(8'hC9);
    do_read(12'h0A5, 8'd1, 1'b0, 1, 0);
    wbuf[0] = 8'h12; wbuf[1] = 8'h34;
    do_write(12'hFFF, 8'd2, 2, 1'b1, -1);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    do_read(12'hFFF, 8'd2, 1'b1, 1, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Responder end of the serial system bus: sits behind one slave port of the interconnect (s1/s2/s3) and terminates master transactions.
- Deserialises the address, burst count and write data, and serves a local word memory.
- Serialises read data back to the master, asserts split while a read fetch is pending, and pulses trans_done at the end of each transaction for the arbiter.

Parameters:
- ADDR_W, 12: address bits shifted in per transaction; local memory depth is 2^ADDR_W words.
- DATA_W, 8: bits per data beat.
- BURST_W, 8: width of the serial burst-count field.
- READ_LAT, 2: cycles from read request (per beat) to first read bit available; legal range 0..15.
- SPLIT_EN, 1: 1 = drive slave_split_en during read fetch wait; 0 = tie it low.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-low reset
- master_valid  in  1  master presents a valid serial bit on rx_address, rx_burst_num or rx_data
- master_ready  in  1  master accepts the tx_data bit this cycle
- rx_address  in  1  serial address, LSB first
- rx_burst_num  in  1  serial burst count, LSB first
- rx_data  in  1  serial write data, LSB first
- write_en  in  1  write request, sampled at start
- read_en  in  1  read request, sampled at start
- tx_data  out  1  serial read data, LSB first
- slave_valid  out  1  tx_data bit valid
- slave_ready  out  1  slave accepts an input bit this cycle
- slave_split_en  out  1  read fetch in progress; bus may be released
- trans_done  out  1  one-cycle pulse after the final beat

Behaviour:
- Reset (sys_rst=0, async): state=IDLE, all counters 0, tx_data=0, slave_valid=0, slave_split_en=0, trans_done=0, slave_ready=1. Memory contents are not reset. Reset mid-transaction aborts immediately; no partial beat is written.
- Transfer rule: an input bit is consumed only on a cycle with master_valid=1 and slave_ready=1. An output bit advances only on a cycle with slave_valid=1 and master_ready=1. Otherwise the current phase stalls indefinitely.
- IDLE:
  - start = master_valid & (write_en ^ read_en). The op is latched and rx_address is captured as address bit 0 in the same cycle; next state is ADDR.
  - write_en=read_en=1 with master_valid=1: ignored, stay IDLE.
- ADDR: capture bits 1..ADDR_W-1, then go to BURST.
- BURST: capture BURST_W bits. The resulting beats value is the burst count, except a count of 0 is treated as 1. After the last bit: write -> WDATA, read -> RWAIT.
- WDATA:
  - Shift in DATA_W bits.
  - On the cycle the last bit is consumed, mem[addr] is written at that edge, addr increments modulo 2^ADDR_W (wrap 4095->0), and the beat count decrements.
  - After the last beat: go to DONE.
  - write_en/read_en are ignored after start.
- RWAIT:
  - slave_ready=0; slave_split_en=SPLIT_EN; counts READ_LAT cycles.
  - mem[addr] is loaded into the shift register at the end of the wait.
  - READ_LAT=0: one cycle in RWAIT for the load.
  - Then go to RDATA.
- RDATA:
  - slave_ready=0, slave_split_en=0, slave_valid=1, tx_data=shift register LSB.
  - Shift on each transferred bit. After DATA_W bits, addr increments with wrap.
  - If more beats remain, go back to RWAIT (slave_valid drops to 0); otherwise go to DONE.
- DONE: trans_done=1 for exactly one cycle, slave_ready=0, then IDLE with slave_ready=1. Earliest next start is the cycle after DONE.
- slave_ready: 1 in IDLE, ADDR, BURST, WDATA; 0 in RWAIT, RDATA, DONE.
- All counters are sized to their maximum value: bit counter up to max(ADDR_W, BURST_W, DATA_W), beat counter BURST_W bits, latency counter 4 bits.

Test Plan:
- Single write then read (defaults): write addr 0x0A5, burst 1, data 0x3C. Expect trans_done once, 12+8+8 input bits consumed, slave_ready high throughout. Read 0x0A5 burst 1: expect slave_split_en high exactly 2 cycles, then tx_data bits 0,0,1,1,1,1,0,0 (LSB first), then trans_done.
- Burst with wrap: write addr 0xFFE, burst 3, data 0x11/0x22/0x33. Read 0x000 burst 1 -> 0x33; read 0xFFE burst 2 -> 0x11, 0x22.
- Stalls: toggle master_valid low randomly during write and master_ready low during read. Data is unchanged and tx_data is held stable while master_ready=0.
- Boundaries: burst field 0 acts as 1 beat. With write_en=read_en=1, no state change and trans_done stays 0. With READ_LAT=0, read data appears 1 cycle after the last burst bit.
- Reset mid-burst: assert sys_rst low during the 2nd beat of a 3-beat write. Outputs go to reset values immediately, only beat 1 is present in memory, and a new write succeeds after release.
- SPLIT_EN=0: a read completes correctly and slave_split_en never asserts.
